// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU control codes, datapath mux selects and the control FSM state set.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Select codes follow the input ordering of the datapath muxes.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU function decode: maps the FSM's alu_op and the instruction funct field
// to the 3-bit ALU control code.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unlisted funct codes quietly fall back to add.
                unique case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main Moore control FSM of the multicycle MIPS datapath; all outputs decode
// from the registered state (pc_en additionally from the ALU zero flag).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op
);

    state_t     state, next;
    logic       pc_write, branch;
    logic [1:0] alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:   next = S_FETCH;
            S_FETCH:  next = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_EXECUTE;
                    OP_BEQ:       next = S_BRANCH;
                    OP_ADDI:      next = S_ADDIEXEC;
                    OP_J:         next = S_JUMP;
                    default:      next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                endcase
            end
            // The IR is only loaded in FETCH, so opcode is still valid here.
            S_MEMADR:   next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    next = S_MEMWB;
            S_EXECUTE:  next = S_ALUWB;
            S_ADDIEXEC: next = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                        next = S_FETCH;
            S_TRAP:     next = S_TRAP;
            default:    next = S_IDLE;
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        unique case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH;
                unique case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                       illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en = pc_write | (branch & zero);

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class through
// two instances (ILLEGAL_TRAP = 0 and 1) and checks packed output vectors.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b100011;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b1;

    logic       a_pc_en, a_iord, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg;
    logic       a_reg_write, a_alu_src_a, a_illegal_op;
    logic [1:0] a_alu_src_b, a_pc_src;
    logic [2:0] a_alu_ctrl;
    logic       b_pc_en, b_iord, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg;
    logic       b_reg_write, b_alu_src_a, b_illegal_op;
    logic [1:0] b_alu_src_b, b_pc_src;
    logic [2:0] b_alu_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(a_pc_en), .iord(a_iord), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .pc_src(a_pc_src),
        .alu_ctrl(a_alu_ctrl), .illegal_op(a_illegal_op)
    );

    multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(b_pc_en), .iord(b_iord), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .pc_src(b_pc_src),
        .alu_ctrl(b_alu_ctrl), .illegal_op(b_illegal_op)
    );

    // {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
    //  alu_src_b[1:0],pc_src[1:0],alu_ctrl[2:0],illegal_op}
    logic [15:0] va, vb;
    assign va = {a_pc_en, a_iord, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg,
                 a_reg_write, a_alu_src_a, a_alu_src_b, a_pc_src, a_alu_ctrl, a_illegal_op};
    assign vb = {b_pc_en, b_iord, b_mem_write, b_ir_write, b_reg_dst, b_mem_to_reg,
                 b_reg_write, b_alu_src_a, b_alu_src_b, b_pc_src, b_alu_ctrl, b_illegal_op};

    localparam logic [15:0] V_IDLE    = 16'h0004;
    localparam logic [15:0] V_FETCH   = 16'h9044;
    localparam logic [15:0] V_DECODE  = 16'h00C4;
    localparam logic [15:0] V_DECILL  = 16'h00C5;
    localparam logic [15:0] V_MEMADR  = 16'h0184;
    localparam logic [15:0] V_MEMRD   = 16'h4004;
    localparam logic [15:0] V_MEMWB   = 16'h0604;
    localparam logic [15:0] V_MEMWR   = 16'h6004;
    localparam logic [15:0] V_EX_ADD  = 16'h0104;
    localparam logic [15:0] V_EX_SUB  = 16'h010C;
    localparam logic [15:0] V_EX_SLT  = 16'h010E;
    localparam logic [15:0] V_EX_AND  = 16'h0100;
    localparam logic [15:0] V_EX_OR   = 16'h0102;
    localparam logic [15:0] V_ALUWB   = 16'h0A04;
    localparam logic [15:0] V_BR_Z1   = 16'h811C;
    localparam logic [15:0] V_BR_Z0   = 16'h011C;
    localparam logic [15:0] V_ADDIWB  = 16'h0204;
    localparam logic [15:0] V_JUMP    = 16'h8024;

    task automatic chk2(input string tag, input logic [15:0] ea, input logic [15:0] eb);
        n_checks++;
        assert (va === ea) else begin
            n_fail++;
            $error("FAIL %s trap0: got %h want %h", tag, va, ea);
        end
        n_checks++;
        assert (vb === eb) else begin
            n_fail++;
            $error("FAIL %s trap1: got %h want %h", tag, vb, eb);
        end
    endtask

    task automatic cyc(input string tag, input logic [15:0] e);
        @(negedge clk);
        chk2(tag, e, e);
    endtask

    initial begin
        // Reset held for 3 cycles with a lw opcode on the bus
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk2("reset_hold", V_IDLE, V_IDLE);
        end
        rst_n = 1'b1;
        #1 chk2("idle_after_release", V_IDLE, V_IDLE);
        cyc("fetch0", V_FETCH);

        // lw: 5 cycles, zero held high to expose stray pc_en
        opcode = 6'b100011; zero = 1'b1;
        cyc("lw_decode", V_DECODE);
        cyc("lw_memadr", V_MEMADR);
        cyc("lw_memrd",  V_MEMRD);
        cyc("lw_memwb",  V_MEMWB);
        cyc("lw_fetch",  V_FETCH);

        // R-type add / sub / slt / and / or
        opcode = 6'b000000; funct = 6'b100000;
        cyc("radd_decode", V_DECODE);
        cyc("radd_exec",   V_EX_ADD);
        cyc("radd_wb",     V_ALUWB);
        cyc("radd_fetch",  V_FETCH);
        funct = 6'b100010;
        cyc("rsub_decode", V_DECODE);
        cyc("rsub_exec",   V_EX_SUB);
        cyc("rsub_wb",     V_ALUWB);
        cyc("rsub_fetch",  V_FETCH);
        funct = 6'b101010;
        cyc("rslt_decode", V_DECODE);
        cyc("rslt_exec",   V_EX_SLT);
        cyc("rslt_wb",     V_ALUWB);
        cyc("rslt_fetch",  V_FETCH);
        funct = 6'b100100;
        cyc("rand_decode", V_DECODE);
        cyc("rand_exec",   V_EX_AND);
        cyc("rand_wb",     V_ALUWB);
        cyc("rand_fetch",  V_FETCH);
        funct = 6'b100101;
        cyc("ror_decode", V_DECODE);
        cyc("ror_exec",   V_EX_OR);
        cyc("ror_wb",     V_ALUWB);
        cyc("ror_fetch",  V_FETCH);
        funct = 6'b111111;
        cyc("runk_decode", V_DECODE);
        cyc("runk_exec",   V_EX_ADD);
        cyc("runk_wb",     V_ALUWB);
        cyc("runk_fetch",  V_FETCH);

        // beq taken then not taken
        opcode = 6'b000100; zero = 1'b1;
        cyc("beq1_decode", V_DECODE);
        cyc("beq1_branch", V_BR_Z1);
        cyc("beq1_fetch",  V_FETCH);
        zero = 1'b0;
        cyc("beq0_decode", V_DECODE);
        cyc("beq0_branch", V_BR_Z0);
        cyc("beq0_fetch",  V_FETCH);
        zero = 1'b1;

        // sw, addi, j
        opcode = 6'b101011;
        cyc("sw_decode", V_DECODE);
        cyc("sw_memadr", V_MEMADR);
        cyc("sw_memwr",  V_MEMWR);
        cyc("sw_fetch",  V_FETCH);
        opcode = 6'b001000;
        cyc("addi_decode", V_DECODE);
        cyc("addi_exec",   V_MEMADR);
        cyc("addi_wb",     V_ADDIWB);
        cyc("addi_fetch",  V_FETCH);
        opcode = 6'b000010;
        cyc("j_decode", V_DECODE);
        cyc("j_jump",   V_JUMP);
        cyc("j_fetch",  V_FETCH);

        // Illegal opcode: trap0 returns to FETCH, trap1 parks
        opcode = 6'b111111;
        cyc("ill_decode", V_DECILL);
        @(negedge clk);
        chk2("ill_next", V_FETCH, V_IDLE);
        opcode = 6'b000010;
        @(negedge clk);
        chk2("ill_after1", V_DECODE, V_IDLE);
        @(negedge clk);
        chk2("ill_after2", V_JUMP, V_IDLE);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            assert (vb === V_IDLE) else begin
                n_fail++;
                $error("FAIL trap_park%0d: got %h want %h", i, vb, V_IDLE);
            end
        end

        // Reset pulse recovers the trapped instance
        rst_n = 1'b0;
        #1 chk2("rst_recover", V_IDLE, V_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk2("rst_recover_idle", V_IDLE, V_IDLE);
        cyc("rec_fetch", V_FETCH);

        // sw again, with reset asserted mid-MEMWR
        opcode = 6'b101011;
        cyc("sw2_decode", V_DECODE);
        cyc("sw2_memadr", V_MEMADR);
        cyc("sw2_memwr",  V_MEMWR);
        #2 rst_n = 1'b0;
        #1 chk2("sw2_abort", V_IDLE, V_IDLE);
        @(negedge clk);
        chk2("sw2_abort_hold", V_IDLE, V_IDLE);
        rst_n = 1'b1;
        cyc("sw2_fetch", V_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
